// File: rtl/assert_ctrl_pkg.sv
// Shared types and constants for the checker-control sequencer.
// The opcode is carried as raw bits so that illegal codes can be queued and reported.
package assert_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LOCK   = 4'd1,
        OP_UNLOCK = 4'd2,
        OP_ON     = 4'd3,
        OP_OFF    = 4'd4,
        OP_KILL   = 4'd5,
        OP_VACON  = 4'd10,
        OP_VACOFF = 4'd11
    } op_e;

    localparam logic [7:0] AT_CONC   = 8'd1;
    localparam logic [7:0] AT_S_IMM  = 8'd2;
    localparam logic [7:0] AT_D_IMM  = 8'd12;
    localparam logic [7:0] AT_EXPECT = 8'd16;
    localparam logic [7:0] AT_UNIQ   = 8'd32;
    localparam logic [7:0] AT_UNIQ0  = 8'd64;
    localparam logic [7:0] AT_PRIO   = 8'd128;
    localparam logic [7:0] ALL_ASSERTS = 8'hFF;

    localparam logic [2:0] DT_ASSERT = 3'd1;
    localparam logic [2:0] DT_COVER  = 3'd2;
    localparam logic [2:0] DT_ASSUME = 3'd4;
    localparam logic [2:0] ALL_DIRECTIVES = 3'd7;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] atype;
        logic [2:0] dtype;
    } cmd_hdr_t;

    function automatic logic mask_hit(input logic [7:0] cmd_at, input logic [2:0] cmd_dt,
                                      input logic [7:0] chk_at, input logic [2:0] chk_dt);
        return (|(cmd_at & chk_at)) && (|(cmd_dt & chk_dt));
    endfunction

endpackage

// File: rtl/assert_ctrl_fifo.sv
// Synchronous command FIFO; push/pop are ignored when full/empty respectively.
module assert_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/assert_ctrl_sched.sv
// Delayed command sequencer driving per-checker enable / vacuous-enable / lock / kill.
// Commands are queued, popped one at a time, held for their delay, then applied.
module assert_ctrl_sched
    import assert_ctrl_pkg::*;
#(
    parameter int N_CHK      = 8,
    parameter int DLY_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CHK*8-1:0] chk_atype,
    input  logic [N_CHK*3-1:0] chk_dtype,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [7:0]         cmd_atype,
    input  logic [2:0]         cmd_dtype,
    input  logic [N_CHK-1:0]   cmd_sel,
    input  logic [DLY_W-1:0]   cmd_delay,
    output logic [N_CHK-1:0]   chk_en,
    output logic [N_CHK-1:0]   chk_vac_en,
    output logic [N_CHK-1:0]   chk_lock,
    output logic [N_CHK-1:0]   chk_kill,
    output logic               cmd_err,
    output logic               busy
);
    typedef struct packed {
        cmd_hdr_t         hdr;
        logic [N_CHK-1:0] sel;
        logic [DLY_W-1:0] delay;
    } cmd_t;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e           state_q, state_d;
    cmd_hdr_t         cur_hdr_q, cur_hdr_d;
    logic [N_CHK-1:0] cur_sel_q, cur_sel_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [N_CHK-1:0] en_q, en_d, vac_q, vac_d, lock_q, lock_d, kill_q, kill_d;
    logic             err_q, err_d;

    cmd_t             wr_cmd, rd_cmd;
    logic             fifo_full, fifo_empty, push, pop;
    logic [N_CHK-1:0] match, live;

    assign wr_cmd = '{hdr: '{op: cmd_op, atype: cmd_atype, dtype: cmd_dtype},
                      sel: cmd_sel, delay: cmd_delay};
    assign push   = cmd_valid && !fifo_full;

    assert_ctrl_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_cmd),
        .rd_data (rd_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        match = '0;
        for (int i = 0; i < N_CHK; i++)
            match[i] = mask_hit(cur_hdr_q.atype, cur_hdr_q.dtype, chk_atype[i*8 +: 8], chk_dtype[i*3 +: 3])
                       && (cur_sel_q == '0 || cur_sel_q[i]);
    end

    // Lock only shields the enable/vacuous/kill ops; LOCK/UNLOCK use the raw match.
    assign live = match & ~lock_q;

    always_comb begin
        state_d   = state_q;
        cur_hdr_d = cur_hdr_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        vac_d     = vac_q;
        lock_d    = lock_q;
        kill_d    = '0;
        err_d     = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    cur_hdr_d = rd_cmd.hdr;
                    cur_sel_d = rd_cmd.sel;
                    cnt_d     = rd_cmd.delay;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    state_d = S_IDLE;
                    case (cur_hdr_q.op)
                        OP_LOCK:   lock_d = lock_q | match;
                        OP_UNLOCK: lock_d = lock_q & ~match;
                        OP_ON:     en_d   = en_q | live;
                        OP_OFF:    en_d   = en_q & ~live;
                        OP_KILL:   kill_d = live;
                        OP_VACON:  vac_d  = vac_q | live;
                        OP_VACOFF: vac_d  = vac_q & ~live;
                        default:   err_d  = 1'b1;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_hdr_q <= '0;
            cur_sel_q <= '0;
            cnt_q     <= '0;
            en_q      <= '1;
            vac_q     <= '1;
            lock_q    <= '0;
            kill_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_hdr_q <= cur_hdr_d;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            vac_q     <= vac_d;
            lock_q    <= lock_d;
            kill_q    <= kill_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign chk_en     = en_q;
    assign chk_vac_en = vac_q;
    assign chk_lock   = lock_q;
    assign chk_kill   = kill_q;
    assign cmd_err    = err_q;

endmodule
